// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell and a registered carry, LSB first, one bit per clock.
// Result is held in registered sum/cout and announced with a single-cycle done pulse.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic bit_s;
  logic bit_c;

  assign bit_s = shift_a_q[0] ^ shift_b_q[0] ^ carry_q;
  assign bit_c = (shift_a_q[0] & shift_b_q[0]) | (shift_a_q[0] & carry_q) |
                 (shift_b_q[0] & carry_q);

  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_a_d = a;
          shift_b_d = b;
          carry_d   = cin;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = StShift;
        end
      end
      StShift: begin
        carry_d   = bit_c;
        shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
        shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
        acc_d     = {bit_s, acc_q[WIDTH-1:1]};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          // Final bit: publish the freshly completed accumulator, not acc_q.
          sum_d   = {bit_s, acc_q[WIDTH-1:1]};
          cout_d  = bit_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_a_q <= '0;
      shift_b_q <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: 8-bit instance for scenarios, 4-bit instance for a sweep.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int done_cnt4 = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done4) done_cnt4++;
  end

  // Issues one request on the 8-bit DUT and reports what was observed; callers compare.
  task automatic do_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        output logic [7:0] rs, output logic rc, output int lat,
                        output int busy_cyc, output bit stable);
    logic [7:0] s0;
    logic       c0;
    s0 = sum; c0 = cout; stable = 1'b1; busy_cyc = 0; lat = -1;
    start = 1'b1; a = ta; b = tb_v; cin = tc;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (sum !== s0 || cout !== c0) stable = 1'b0;
    end
    rs = sum; rc = cout;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    tests_run++;
    if ({busy, done, sum, cout} !== 11'b0) begin
      tests_failed++;
      $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
    end
    tests_run++;
    if ({busy4, done4, sum4, cout4} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset4: got busy=%b done=%b sum=%h cout=%b, want all 0",
               busy4, done4, sum4, cout4);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] rs; logic rc; int lat, bc; bit st;
    do_add(8'h3C, 8'h42, 1'b0, rs, rc, lat, bc, st);
    tests_run++;
    if ({rc, rs} !== 9'h07E) begin
      tests_failed++;
      $display("FAIL basic_sum: got %b_%h, want 0_7e", rc, rs);
    end
    tests_run++;
    if (lat !== 8) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d, want 8", lat);
    end
    tests_run++;
    if (bc !== 8) begin
      tests_failed++;
      $display("FAIL basic_busy_cycles: got %0d, want 8", bc);
    end
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b, want 0 0", done, busy);
    end
    tests_run++;
    if (!st) begin
      tests_failed++;
      $display("FAIL basic_stable: sum/cout moved before completion, want stable");
    end
  endtask

  task automatic test_carry();
    logic [7:0] rs; logic rc; int lat, bc; bit st;
    do_add(8'hFF, 8'h01, 1'b0, rs, rc, lat, bc, st);
    tests_run++;
    if ({rc, rs} !== 9'h100) begin
      tests_failed++;
      $display("FAIL carry_ff01: got %b_%h, want 1_00", rc, rs);
    end
    do_add(8'h5A, 8'hA5, 1'b1, rs, rc, lat, bc, st);
    tests_run++;
    if ({rc, rs} !== 9'h100) begin
      tests_failed++;
      $display("FAIL carry_5aa5: got %b_%h, want 1_00", rc, rs);
    end
  endtask

  task automatic test_cin_stable();
    logic [7:0] rs; logic rc; int lat, bc; bit st;
    do_add(8'h00, 8'h00, 1'b1, rs, rc, lat, bc, st);
    tests_run++;
    if ({rc, rs} !== 9'h001) begin
      tests_failed++;
      $display("FAIL cin_only: got %b_%h, want 0_01", rc, rs);
    end
    tests_run++;
    if (!st) begin
      tests_failed++;
      $display("FAIL hold_prev: previous 1_00 not held during shift, want stable");
    end
  endtask

  task automatic test_ignore_start();
    int d0, ndone;
    logic [7:0] rs; logic rc;
    d0 = done_cnt; ndone = 0; rs = 'x; rc = 1'bx;
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    @(posedge clk); #1;  // E0
    start = 1'b0;
    @(posedge clk); #1;  // E1
    @(posedge clk); #1;  // E2
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(posedge clk); #1;  // E3
    start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        rs = sum; rc = cout;
      end
    end
    tests_run++;
    if ({rc, rs} !== 9'h030) begin
      tests_failed++;
      $display("FAIL ignore_start_sum: got %b_%h, want 0_30", rc, rs);
    end
    tests_run++;
    if (ndone !== 1 || done_cnt - d0 !== 1) begin
      tests_failed++;
      $display("FAIL ignore_start_pulses: got %0d, want 1", ndone);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rs; logic rc; int lat, bc; bit st; int d0;
    start = 1'b1; a = 8'hC3; b = 8'h77; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, sum, cout} !== 11'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_clear: got busy=%b done=%b sum=%h cout=%b, want all 0",
               busy, done, sum, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) @(posedge clk);
    #1;
    tests_run++;
    if (done_cnt !== d0) begin
      tests_failed++;
      $display("FAIL reset_mid_nodone: got %0d pulses, want 0", done_cnt - d0);
    end
    do_add(8'h81, 8'h81, 1'b0, rs, rc, lat, bc, st);
    tests_run++;
    if ({rc, rs} !== 9'h102 || lat !== 8) begin
      tests_failed++;
      $display("FAIL reset_mid_next: got %b_%h lat %0d, want 1_02 lat 8", rc, rs, lat);
    end
  endtask

  task automatic test_back_to_back();
    int starts, d0, lat;
    logic [4:0] want;
    starts = 0; d0 = done_cnt4;
    for (int x = 0; x < 512; x++) begin
      a4 = 4'(x); b4 = 4'(x >> 4); cin4 = 1'(x >> 8);
      want = 5'(x & 15) + 5'((x >> 4) & 15) + 5'((x >> 8) & 1);
      start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      starts++;
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (done4) begin
          lat = k;
          break;
        end
      end
      tests_run++;
      if ({cout4, sum4} !== want || lat !== 4) begin
        tests_failed++;
        $display("FAIL sweep a=%h b=%h cin=%b: got %b_%h lat %0d, want %b_%h lat 4",
                 x & 15, (x >> 4) & 15, (x >> 8) & 1, cout4, sum4, lat, want[4], want[3:0]);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (done_cnt4 - d0 !== starts) begin
      tests_failed++;
      $display("FAIL sweep_done_count: got %0d, want %0d", done_cnt4 - d0, starts);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_cin_stable();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
